// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control unit: exception FSM states,
// canonical stage indices and default depth/stage assignments.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    REDIR = 2'd2
  } exc_state_t;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;

  localparam int DEF_NSTAGES     = 5;
  localparam int DEF_REDIR_STAGE = STG_D;
  localparam int DEF_EXC_STAGE   = STG_M;

  // Bits 0..hi set; a negative hi yields an empty mask.
  function automatic logic [63:0] range_mask(input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if (i <= hi) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running stall-cycle and flush-event counters, wrapping at 2^32.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_evt,
  input  logic        flush_evt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt) stall_cnt <= stall_cnt + 32'd1;
      if (flush_evt) flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/valid control with branch redirect and drain-then-flush exceptions.
// Performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int NSTAGES     = DEF_NSTAGES,
  parameter int XLEN        = 32,
  parameter int REDIR_STAGE = DEF_REDIR_STAGE,
  parameter int EXC_STAGE   = DEF_EXC_STAGE,
  parameter int DELAY_SLOT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_valid,
  input  logic [NSTAGES-1:0] stall_req,
  input  logic               mem_busy,
  input  logic               redir_req,
  input  logic [XLEN-1:0]    redir_target,
  input  logic               exc_req,
  input  logic [XLEN-1:0]    exc_target,
  output logic [NSTAGES-1:0] stage_en,
  output logic [NSTAGES-1:0] stage_flush,
  output logic [NSTAGES-1:0] stage_valid,
  output logic               pc_redirect,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               exc_busy,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
);

  localparam logic [63:0] BR_FLUSH64 = range_mask(REDIR_STAGE - 1 - DELAY_SLOT);
  localparam logic [63:0] EXC_HOLD64 = range_mask(EXC_STAGE);
  localparam logic [NSTAGES-1:0] BR_FLUSH = BR_FLUSH64[NSTAGES-1:0];
  localparam logic [NSTAGES-1:0] EXC_HOLD = EXC_HOLD64[NSTAGES-1:0];

  exc_state_t         state;
  logic [XLEN-1:0]    exc_pc;
  logic [NSTAGES-1:0] valid;
  logic [NSTAGES-1:0] nxt_valid;
  logic [NSTAGES-1:0] shifted;
  logic [NSTAGES-1:0] req_eff;
  logic [NSTAGES-1:0] stall;
  logic [NSTAGES-1:0] flush;
  logic               exc_accept;
  logic               br_take;

  always_comb begin
    // During the redirect cycle the flushed stages' own requests (e.g. divider) are moot.
    req_eff = (state == REDIR) ? (stall_req & ~EXC_HOLD) : stall_req;
    stall   = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      stall[i] = |(req_eff >> i);
    end
    if (state == DRAIN) stall = stall | EXC_HOLD;

    exc_accept = (state == IDLE) && exc_req && valid[EXC_STAGE];
    br_take    = redir_req && valid[REDIR_STAGE] && !stall[REDIR_STAGE]
                 && !exc_accept && (state != REDIR);

    flush = {stall[NSTAGES-2:0] & ~stall[NSTAGES-1:1], 1'b0};
    if (br_take)        flush = flush | BR_FLUSH;
    if (state == REDIR) flush = flush | EXC_HOLD;

    shifted   = {valid[NSTAGES-2:0], fetch_valid};
    nxt_valid = ((shifted & ~stall) | (valid & stall)) & ~flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid <= '0;
    else      valid <= nxt_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      exc_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (exc_accept) begin
            exc_pc <= exc_target;
            state  <= mem_busy ? DRAIN : REDIR;
          end
        end
        DRAIN:   if (!mem_busy) state <= REDIR;
        REDIR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stage_en    = ~stall;
  assign stage_flush = flush;
  assign stage_valid = valid;
  assign exc_busy    = (state != IDLE);
  assign pc_redirect = (state == REDIR) || br_take;
  assign redirect_pc = (state == REDIR) ? exc_pc : (br_take ? redir_target : '0);

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_cnt u_perf (
    .clk       (clk),
    .rst       (rst),
    .stall_evt (stall[0]),
    .flush_evt (|flush),
    .stall_cnt (perf_stall_cnt),
    .flush_cnt (perf_flush_cnt)
  );
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (delay slot on/off) driven in lockstep, checked against a cycle model.
module tb_pipe_ctrl;
  localparam int N = 5;
  localparam int R = 1;
  localparam int E = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [4:0]  stall_req;
  logic        mem_busy;
  logic        redir_req;
  logic [31:0] redir_target;
  logic        exc_req;
  logic [31:0] exc_target;

  logic [4:0]  en_o[2];
  logic [4:0]  fl_o[2];
  logic [4:0]  val_o[2];
  logic        pcr_o[2];
  logic [31:0] rpc_o[2];
  logic        busy_o[2];
  logic [31:0] psc_o[2];
  logic [31:0] pfc_o[2];

  int tests = 0;
  int fails = 0;

  // Model state; index 0 = DELAY_SLOT 1, index 1 = DELAY_SLOT 0. mst: 0 idle, 1 drain, 2 redirect.
  logic [4:0]  mv[2];
  int          mst[2];
  logic [31:0] mtgt[2];
  logic [31:0] msc[2];
  logic [31:0] mfc[2];
  logic [4:0]  e_en[2];
  logic [4:0]  e_fl[2];
  logic        e_pcr[2];
  logic [31:0] e_rpc[2];
  logic        e_busy[2];

  always #5 clk = ~clk;

  pipe_ctrl #(.NSTAGES(5), .XLEN(32), .REDIR_STAGE(1), .EXC_STAGE(3), .DELAY_SLOT(1)) u_ds1 (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .stall_req(stall_req), .mem_busy(mem_busy),
    .redir_req(redir_req), .redir_target(redir_target), .exc_req(exc_req), .exc_target(exc_target),
    .stage_en(en_o[0]), .stage_flush(fl_o[0]), .stage_valid(val_o[0]), .pc_redirect(pcr_o[0]),
    .redirect_pc(rpc_o[0]), .exc_busy(busy_o[0]), .perf_stall_cnt(psc_o[0]), .perf_flush_cnt(pfc_o[0]));

  pipe_ctrl #(.NSTAGES(5), .XLEN(32), .REDIR_STAGE(1), .EXC_STAGE(3), .DELAY_SLOT(0)) u_ds0 (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .stall_req(stall_req), .mem_busy(mem_busy),
    .redir_req(redir_req), .redir_target(redir_target), .exc_req(exc_req), .exc_target(exc_target),
    .stage_en(en_o[1]), .stage_flush(fl_o[1]), .stage_valid(val_o[1]), .pc_redirect(pcr_o[1]),
    .redirect_pc(rpc_o[1]), .exc_busy(busy_o[1]), .perf_stall_cnt(psc_o[1]), .perf_flush_cnt(pfc_o[1]));

  task automatic model_reset(input int d);
    mv[d] = '0; mst[d] = 0; mtgt[d] = '0; msc[d] = '0; mfc[d] = '0;
  endtask

  task automatic model_eval(input int d);
    logic [4:0] st, fl;
    logic accept, take;
    int ds;
    ds = (d == 0) ? 1 : 0;
    accept = (mst[d] == 0) && exc_req && mv[d][E];
    for (int i = 0; i < N; i++) begin
      st[i] = (mst[d] == 1) && (i <= E);
      for (int j = i; j < N; j++)
        if (stall_req[j] && !(mst[d] == 2 && j <= E)) st[i] = 1'b1;
    end
    fl = '0;
    for (int i = 0; i + 1 < N; i++) if (st[i] && !st[i+1]) fl[i+1] = 1'b1;
    take = redir_req && mv[d][R] && !st[R] && !accept && (mst[d] != 2);
    if (take) for (int i = 0; i < R - ds; i++) fl[i] = 1'b1;
    if (mst[d] == 2) for (int i = 0; i <= E; i++) fl[i] = 1'b1;
    e_en[d]   = ~st;
    e_fl[d]   = fl;
    e_pcr[d]  = (mst[d] == 2) || take;
    e_rpc[d]  = (mst[d] == 2) ? mtgt[d] : (take ? redir_target : 32'h0);
    e_busy[d] = (mst[d] != 0);
  endtask

  task automatic model_step(input int d);
    logic [4:0] nv;
    logic [5:0] chain;
    if (!rst) begin
      model_reset(d);
      return;
    end
    chain = {mv[d], fetch_valid};
    for (int i = 0; i < N; i++) begin
      if (e_fl[d][i])      nv[i] = 1'b0;
      else if (e_en[d][i]) nv[i] = chain[i];
      else                 nv[i] = mv[d][i];
    end
    if (!e_en[d][0]) msc[d] = msc[d] + 32'd1;
    if (e_fl[d] != 5'b0) mfc[d] = mfc[d] + 32'd1;
    case (mst[d])
      0: if (exc_req && mv[d][E]) begin
           mtgt[d] = exc_target;
           mst[d]  = mem_busy ? 1 : 2;
         end
      1: if (!mem_busy) mst[d] = 2;
      default: mst[d] = 0;
    endcase
    mv[d] = nv;
  endtask

  function automatic logic [112:0] obs_vec(input int d);
    return {en_o[d], fl_o[d], val_o[d], pcr_o[d], rpc_o[d], busy_o[d], psc_o[d], pfc_o[d]};
  endfunction

  function automatic logic [112:0] exp_vec(input int d);
    logic [31:0] ps, pf;
    ps = '0; pf = '0;
`ifdef PIPE_PERF_CNT_EN
    ps = msc[d]; pf = mfc[d];
`endif
    return {e_en[d], e_fl[d], mv[d], e_pcr[d], e_rpc[d], e_busy[d], ps, pf};
  endfunction

  task automatic settle();
    #1;
    if (!rst) begin model_reset(0); model_reset(1); end
    model_eval(0);
    model_eval(1);
  endtask

  task automatic step_cycle();
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    fetch_valid = 0; stall_req = '0; mem_busy = 0; redir_req = 0; exc_req = 0;
    redir_target = '0; exc_target = '0;
  endtask

  task automatic idle_cycles(input int n);
    quiet_inputs();
    fetch_valid = 1;
    for (int k = 0; k < n; k++) begin settle(); step_cycle(); end
  endtask

  task automatic test_reset();
    logic [48:0] got;
    rst = 0;
    quiet_inputs();
    settle();
    got = {val_o[0], en_o[0], fl_o[0], pcr_o[0], busy_o[0], rpc_o[0]};
    tests++;
    if (got !== {5'b0, 5'h1f, 5'b0, 1'b0, 1'b0, 32'h0}) begin
      fails++; $display("FAIL reset_values got %h required %h", got, {5'b0, 5'h1f, 5'b0, 1'b0, 1'b0, 32'h0});
    end
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (obs_vec(d) !== exp_vec(d)) begin
        fails++; $display("FAIL reset_model dut%0d got %h required %h", d, obs_vec(d), exp_vec(d));
      end
    end
    step_cycle();
  endtask

  task automatic test_fill();
    logic [4:0] exp_v;
    rst = 1;
    fetch_valid = 1;
    for (int k = 0; k < 7; k++) begin
      settle();
      exp_v = (k >= 5) ? 5'h1f : 5'((1 << k) - 1);
      tests++;
      if (val_o[0] !== exp_v || en_o[0] !== 5'h1f) begin
        fails++; $display("FAIL fill cycle %0d valid %b en %b required valid %b en 11111", k, val_o[0], en_o[0], exp_v);
      end
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs_vec(d) !== exp_vec(d)) begin
          fails++; $display("FAIL fill_model dut%0d got %h required %h", d, obs_vec(d), exp_vec(d));
        end
      end
      step_cycle();
    end
  endtask

  task automatic test_stall();
    stall_req = 5'b00100;
    for (int k = 0; k < 3; k++) begin
      settle();
      tests++;
      if (en_o[0] !== 5'b11000 || fl_o[0] !== 5'b01000 || (k > 0 && val_o[0][3] !== 1'b0)) begin
        fails++; $display("FAIL div_stall cycle %0d en %b flush %b valid %b required en 11000 flush 01000", k, en_o[0], fl_o[0], val_o[0]);
      end
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs_vec(d) !== exp_vec(d)) begin
          fails++; $display("FAIL stall_model dut%0d got %h required %h", d, obs_vec(d), exp_vec(d));
        end
      end
      step_cycle();
    end
    stall_req = '0;
    settle();
    step_cycle();
  endtask

  task automatic test_branch();
    redir_req = 1; redir_target = 32'hBFC00100; fetch_valid = 1;
    settle();
    tests++;
    if (pcr_o[0] !== 1'b1 || rpc_o[0] !== 32'hBFC00100 || fl_o[0] !== 5'b0) begin
      fails++; $display("FAIL branch_ds1 pcr %b pc %h flush %b required 1 bfc00100 00000", pcr_o[0], rpc_o[0], fl_o[0]);
    end
    tests++;
    if (pcr_o[1] !== 1'b1 || rpc_o[1] !== 32'hBFC00100 || fl_o[1] !== 5'b00001) begin
      fails++; $display("FAIL branch_ds0 pcr %b pc %h flush %b required 1 bfc00100 00001", pcr_o[1], rpc_o[1], fl_o[1]);
    end
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (obs_vec(d) !== exp_vec(d)) begin
        fails++; $display("FAIL branch_model dut%0d got %h required %h", d, obs_vec(d), exp_vec(d));
      end
    end
    step_cycle();
    redir_req = 0;
    settle();
    tests++;
    if (val_o[0][0] !== 1'b1 || val_o[1][0] !== 1'b0) begin
      fails++; $display("FAIL delay_slot valid0 ds1 %b ds0 %b required 1 0", val_o[0][0], val_o[1][0]);
    end
    step_cycle();
  endtask

  task automatic test_exc();
    idle_cycles(5);
    exc_req = 1; exc_target = 32'hBFC00380; mem_busy = 0;
    settle();
    tests++;
    if (busy_o[0] !== 1'b0 || pcr_o[0] !== 1'b0) begin
      fails++; $display("FAIL exc_accept busy %b pcr %b required 0 0", busy_o[0], pcr_o[0]);
    end
    step_cycle();
    exc_req = 0;
    settle();
    tests++;
    if (pcr_o[0] !== 1'b1 || rpc_o[0] !== 32'hBFC00380 || fl_o[0] !== 5'b01111 || busy_o[0] !== 1'b1) begin
      fails++; $display("FAIL exc_redir pcr %b pc %h flush %b busy %b required 1 bfc00380 01111 1", pcr_o[0], rpc_o[0], fl_o[0], busy_o[0]);
    end
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (obs_vec(d) !== exp_vec(d)) begin
        fails++; $display("FAIL exc_model dut%0d got %h required %h", d, obs_vec(d), exp_vec(d));
      end
    end
    step_cycle();
    settle();
    tests++;
    if (busy_o[0] !== 1'b0 || pcr_o[0] !== 1'b0) begin
      fails++; $display("FAIL exc_done busy %b pcr %b required 0 0", busy_o[0], pcr_o[0]);
    end
    step_cycle();
  endtask

  task automatic test_exc_drain();
    idle_cycles(5);
    redir_req = 1; redir_target = 32'h00001234;
    for (int c = 0; c < 6; c++) begin
      exc_req    = (c == 0) || (c == 2);
      exc_target = (c == 0) ? 32'hBFC00380 : 32'hDEAD0000;
      mem_busy   = (c < 4);
      settle();
      tests++;
      if (c == 0) begin
        if (pcr_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
          fails++; $display("FAIL drain_accept pcr %b busy %b required 0 0", pcr_o[0], busy_o[0]);
        end
      end else if (c < 5) begin
        if (en_o[0] !== 5'b10000 || pcr_o[0] !== 1'b0 || busy_o[0] !== 1'b1) begin
          fails++; $display("FAIL drain_hold cycle %0d en %b pcr %b busy %b required 10000 0 1", c, en_o[0], pcr_o[0], busy_o[0]);
        end
      end else begin
        if (pcr_o[0] !== 1'b1 || rpc_o[0] !== 32'hBFC00380 || fl_o[0] !== 5'b01111) begin
          fails++; $display("FAIL drain_redir pcr %b pc %h flush %b required 1 bfc00380 01111", pcr_o[0], rpc_o[0], fl_o[0]);
        end
      end
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs_vec(d) !== exp_vec(d)) begin
          fails++; $display("FAIL drain_model cycle %0d dut%0d got %h required %h", c, d, obs_vec(d), exp_vec(d));
        end
      end
      step_cycle();
    end
    quiet_inputs();
    settle();
    step_cycle();
  endtask

  task automatic test_reset_mid();
    logic [48:0] got;
    idle_cycles(5);
    exc_req = 1; exc_target = 32'hBFC00380; mem_busy = 1;
    settle(); step_cycle();
    exc_req = 0;
    settle();
    tests++;
    if (busy_o[0] !== 1'b1) begin
      fails++; $display("FAIL mid_drain busy %b required 1", busy_o[0]);
    end
    step_cycle();
    rst = 0;
    quiet_inputs();
    settle();
    got = {val_o[0], en_o[0], fl_o[0], pcr_o[0], busy_o[0], rpc_o[0]};
    tests++;
    if (got !== {5'b0, 5'h1f, 5'b0, 1'b0, 1'b0, 32'h0}) begin
      fails++; $display("FAIL mid_reset got %h required %h", got, {5'b0, 5'h1f, 5'b0, 1'b0, 1'b0, 32'h0});
    end
    step_cycle();
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      settle();
      tests++;
      if (pcr_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
        fails++; $display("FAIL post_reset cycle %0d pcr %b busy %b required 0 0", k, pcr_o[0], busy_o[0]);
      end
      step_cycle();
    end
  endtask

  task automatic test_perf();
    logic [31:0] exp_cnt;
    rst = 0; quiet_inputs(); settle(); step_cycle();
    rst = 1; settle(); step_cycle();
    stall_req = 5'b00001;
    for (int k = 0; k < 7; k++) begin settle(); step_cycle(); end
    stall_req = '0;
    settle();
`ifdef PIPE_PERF_CNT_EN
    exp_cnt = 32'd7;
`else
    exp_cnt = 32'd0;
`endif
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (psc_o[d] !== exp_cnt || pfc_o[d] !== exp_cnt) begin
        fails++; $display("FAIL perf dut%0d stall %0d flush %0d required %0d", d, psc_o[d], pfc_o[d], exp_cnt);
      end
    end
    step_cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst          = ($urandom_range(0, 99) != 0);
      fetch_valid  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) stall_req[i] = ($urandom_range(0, 9) == 0);
      mem_busy     = $urandom_range(0, 1);
      redir_req    = ($urandom_range(0, 3) == 0);
      exc_req      = ($urandom_range(0, 7) == 0);
      redir_target = $urandom;
      exc_target   = $urandom;
      settle();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs_vec(d) !== exp_vec(d)) begin
          fails++; $display("FAIL random cycle %0d dut%0d got %h required %h", c, d, obs_vec(d), exp_vec(d));
        end
      end
      step_cycle();
    end
  endtask

  initial begin
    rst = 0;
    quiet_inputs();
    @(negedge clk);
    test_reset();
    test_fill();
    test_stall();
    test_branch();
    test_exc();
    test_exc_drain();
    test_reset_mid();
    test_perf();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
